// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-buffer entry type for the fetch unit.
package fetch_pkg;

    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    localparam int unsigned ENTRY_PC_W    = 8;
    localparam int unsigned ENTRY_INSTR_W = 16;

    // Entry view at the default widths; the top packs {pc, instr} in this order.
    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch FIFO with synchronous flush; push while full is legal when popping.
module fetch_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[head_q];

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= wdata;
                tail_q        <= tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= head_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with a small prefetch buffer and redirect; define FETCH_HALT_EN
// to stop fetching after a HALT_OPCODE word has been buffered.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = 16,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               halted
);
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [PC_W-1:0]    fetch_pc_q;
    logic               buf_empty;
    logic               buf_full;
    logic               pop;
    logic               push;
    logic               halt_q;
    logic [ENTRY_W-1:0] head_entry;

    assign rom_addr  = fetch_pc_q;
    assign out_valid = !buf_empty;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = !halt_q && !redirect_valid && (!buf_full || pop);
    assign {out_pc, out_instr} = head_entry;
    assign halted    = halt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + 1'b1;
        end
    end

`ifdef FETCH_HALT_EN
    // The HALT word itself is pushed; only subsequent pushes are blocked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else if (redirect_valid) begin
            halt_q <= 1'b0;
        end else if (push && (rom_data == INSTR_W'(HALT_OPCODE))) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign halt_q = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({fetch_pc_q, rom_data}),
        .pop   (pop),
        .rdata (head_entry),
        .empty (buf_empty),
        .full  (buf_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected PCs go into a scoreboard when stimulus is
// driven and are checked against every accepted handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [15:0] out_instr;
    logic        halted;
    logic        halt_rom = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    fetch_unit #(
        .PC_W     (8),
        .INSTR_W  (16),
        .DEPTH    (2),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (halt_rom && a == 8'h03) return 16'hFFFF;
        return {~a, a};
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        tick();
        check("rst_pc", {24'd0, out_pc}, 32'd0);
        check("rst_instr", {16'd0, out_instr}, 32'd0);
        check("rst_addr", {24'd0, rom_addr}, 32'd0);
        reset = 1'b0;
        sb.delete();
    endtask

    // Accepted handshakes are checked against the scoreboard; inputs are stable here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {24'd0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [7:0] e = sb.pop_front();
                check("pop_pc", {24'd0, out_pc}, {24'd0, e});
                check("pop_instr", {16'd0, out_instr}, {16'd0, rom_word(e)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming from reset at one instruction per cycle
        do_reset();
        out_ready = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
        check("stream_c0_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_pc", {24'd0, out_pc}, i);
            check("stream_halted", {31'd0, halted}, 32'd0);
        end
        tick();
        out_ready = 1'b0;
        check("stream_sb_empty", sb.size(), 32'd0);

        // Stall fills the buffer, then drains without loss
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc", {24'd0, out_pc}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        check("stall_addr", {24'd0, rom_addr}, 32'd2);
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        check("stall_sb_empty", sb.size(), 32'd0);

        // Redirect flushes buffered PCs 5,6
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        tick();
        redirect_valid = 1'b0;
        check("redir5_gap", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        check("redir5_head", {24'd0, out_pc}, 32'h05);
        check("redir5_addr", {24'd0, rom_addr}, 32'h07);
        sb.push_back(8'h40); sb.push_back(8'h41);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("redir40_gap", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir40_valid", {31'd0, out_valid}, 32'd1);
        check("redir40_pc", {24'd0, out_pc}, 32'h40);
        tick();
        tick();
        out_ready = 1'b0;
        check("redir40_sb_empty", sb.size(), 32'd0);

        // PC wraps from FF to 00
        sb.delete();
        sb.push_back(8'hFE); sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'h01);
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("wrap_gap", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_valid", {31'd0, out_valid}, 32'd1);
        end
        tick();
        out_ready = 1'b0;
        check("wrap_sb_empty", sb.size(), 32'd0);

`ifdef FETCH_HALT_EN
        // HALT word at PC 3 is delivered, then fetch stops until redirect
        halt_rom = 1'b1;
        do_reset();
        out_ready = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
        for (int i = 0; i < 4; i++) tick();
        check("halt_set", {31'd0, halted}, 32'd1);
        check("halt_pc3", {24'd0, out_pc}, 32'h03);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_idle", {31'd0, out_valid}, 32'd0);
        end
        check("halt_addr", {24'd0, rom_addr}, 32'h04);
        check("halt_sb_empty", sb.size(), 32'd0);
        sb.push_back(8'h00);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        tick();
        redirect_valid = 1'b0;
        check("halt_clear", {31'd0, halted}, 32'd0);
        tick();
        check("halt_resume_pc", {24'd0, out_pc}, 32'h00);
        tick();
        out_ready = 1'b0;
        check("halt_resume_sb", sb.size(), 32'd0);
        halt_rom = 1'b0;
`endif

        // Reset asserted mid-redirect with a full buffer
        do_reset();
        tick();
        tick();
        tick();
        check("fill_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_addr", {24'd0, rom_addr}, 32'd0);
        check("async_pc", {24'd0, out_pc}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        reset          = 1'b0;
        sb.push_back(8'h00);
        out_ready = 1'b1;
        tick();
        check("after_rst_pc", {24'd0, out_pc}, 32'd0);
        tick();
        out_ready = 1'b0;
        check("after_rst_sb", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, program counter and ROM address width in bits.
REQ-002 Parameter INSTR_W, default 16, instruction word width in bits.
REQ-003 Parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-004 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rom_addr  output  PC_W  fetch address to combinational instruction ROM.
REQ-008 rom_data  input  INSTR_W  ROM word for rom_addr, valid in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump request from later stage.
REQ-010 redirect_pc  input  PC_W  target PC for redirect.
REQ-011 out_valid  output  1  buffer head holds an instruction for decode.
REQ-012 out_ready  input  1  decode accepts head this cycle.
REQ-013 out_pc  output  PC_W  PC of head instruction.
REQ-014 out_instr  output  INSTR_W  head instruction word.
REQ-015 halted  output  1  fetch stopped by HALT (FETCH_HALT_EN only; tied 0 otherwise).

Function
REQ-016 rom_addr SHALL always equal the internal fetch_pc register.
REQ-017 Push: when not halted, no redirect, and (buffer not full or pop this cycle), {fetch_pc, rom_data} SHALL be written to the buffer tail and fetch_pc SHALL increment by 1 modulo 2^PC_W (all-ones wraps to 0).
REQ-018 Full buffer with no pop: no push, fetch_pc held.
REQ-019 out_valid SHALL be 1 whenever the buffer is non-empty; out_pc/out_instr SHALL show the head entry.
REQ-020 Pop SHALL occur when out_valid and out_ready are both 1; out_pc/out_instr SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous push and pop SHALL be legal at any occupancy, including full; occupancy unchanged.
REQ-022 Latency: an instruction pushed at edge N SHALL be visible with out_valid=1 in the cycle after edge N.
REQ-023 Redirect SHALL take priority: on redirect_valid=1 the buffer SHALL be flushed, fetch_pc SHALL load redirect_pc, no push occurs, any same-cycle pop is discarded, and halted SHALL clear.
REQ-024 After redirect at edge N, out_valid SHALL be 0 in cycle N+1 and the instruction at redirect_pc SHALL appear in cycle N+2.
REQ-025 With sustained out_ready=1 and no redirect, throughput SHALL be one instruction per cycle.

Reset
REQ-026 Reset SHALL set fetch_pc=RESET_PC, buffer empty, out_valid=0, halted=0, immediately and asynchronously, including mid-stall or mid-redirect.
REQ-027 out_pc and out_instr SHALL reset to 0.

Configuration
REQ-028 Macro FETCH_HALT_EN defined: a pushed word equal to HALT_OPCODE SHALL be buffered normally, then set halted=1 and block further pushes until redirect or reset.
REQ-029 Macro FETCH_HALT_EN undefined: no opcode decode, halted tied 0, fetch never self-stops.

Structure
REQ-030 Package fetch_pkg SHALL hold HALT_OPCODE (16'hFFFF) and the buffer-entry struct typedef {pc, instr}.
REQ-031 The buffer SHALL be a sub-module fetch_fifo (synchronous-flush circular FIFO, parametrised width/depth).

Verification
REQ-032 Reset release, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles from cycle 1, out_valid continuous.
REQ-033 out_ready=0 for 5 cycles after reset -> buffer fills to DEPTH=2, fetch_pc holds at 2, out_pc stays 0; ready=1 -> 0,1,2 in sequence without loss.
REQ-034 Redirect to 8'h40 while buffer holds PCs 5,6 -> PCs 5,6 never accepted, out_valid=0 one cycle, next out_pc=8'h40.
REQ-035 Redirect to 8'hFE, out_ready=1 -> out_pc FE, FF, 00, 01 (wrap).
REQ-036 FETCH_HALT_EN, ROM word FFFF at PC 3 -> PC 3 delivered, halted=1, no PC 4; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-037 Assert reset during redirect cycle with full buffer -> out_valid=0 immediately, first output after release is RESET_PC.
